// File: rtl/portgroup_mem_initiator_pkg.sv
// Shared types for the port-group memory initiator: command opcodes and FSM states.
package portgroup_mem_initiator_pkg;

    typedef enum logic [1:0] {
        OpRead  = 2'd0,
        OpWrite = 2'd1,
        OpRmw   = 2'd2,
        OpRsvd  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd   = 3'd1,
        StRcap = 3'd2,
        StWr   = 3'd3,
        StWcap = 3'd4,
        StResp = 3'd5
    } state_e;

    localparam logic [7:0] ErrCntMax = 8'hFF;

endpackage

// File: rtl/portgroup_mem_initiator_if.sv
// Command, memory and response signals of the initiator, with a DUT-side (slave)
// and an environment-side (master) view.
interface portgroup_mem_initiator_if #(
    parameter int unsigned addr_width_p = 13,
    parameter int unsigned data_width_p = 32
);
    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic [1:0]              cmd_op_i;
    logic [addr_width_p-1:0] cmd_addr_i;
    logic [data_width_p-1:0] cmd_wdata_i;
    logic [data_width_p-1:0] cmd_mask_i;

    logic                    mem_ena_o;
    logic [addr_width_p-1:0] mem_addr_o;
    logic                    mem_wena_o;
    logic [data_width_p-1:0] mem_wdata_o;
    logic [data_width_p-1:0] mem_rdata_i;
    logic                    mem_err_i;

    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [data_width_p-1:0] rsp_rdata_o;
    logic                    rsp_err_o;

    logic                    busy_o;
    logic [7:0]              err_cnt_o;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_wdata_i, cmd_mask_i,
        output cmd_ready_o,
        output mem_ena_o, mem_addr_o, mem_wena_o, mem_wdata_o,
        input  mem_rdata_i, mem_err_i,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output busy_o, err_cnt_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_wdata_i, cmd_mask_i,
        input  cmd_ready_o,
        input  mem_ena_o, mem_addr_o, mem_wena_o, mem_wdata_o,
        output mem_rdata_i, mem_err_i,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  busy_o, err_cnt_o
    );

endinterface

// File: rtl/portgroup_mem_initiator.sv
// Single-outstanding memory initiator: READ, WRITE and read-modify-write commands
// are turned into one-cycle memory strobes and a held response.
module portgroup_mem_initiator
    import portgroup_mem_initiator_pkg::*;
#(
    parameter int unsigned addr_width_p = 13,
    parameter int unsigned data_width_p = 32
) (
    input logic                     main_clk_i,
    input logic                     main_rst_i,
    portgroup_mem_initiator_if.slave bus
);

    state_e                  r_state;
    state_e                  w_state_nxt;
    op_e                     r_op;
    logic [addr_width_p-1:0] r_addr;
    logic [data_width_p-1:0] r_wdata;
    logic [data_width_p-1:0] r_mask;
    logic [data_width_p-1:0] r_rsp_rdata;
    logic                    r_rsp_err;
    logic [7:0]              r_err_cnt;

    logic                    w_accept;
    logic                    w_rsp_hs;
    logic                    w_mem_ena;
    logic                    w_mem_wena;
    op_e                     w_cmd_op;

    assign w_cmd_op = op_e'(bus.cmd_op_i);
    assign w_accept = bus.cmd_valid_i && (r_state == StIdle);
    assign w_rsp_hs = bus.rsp_ready_i && (r_state == StResp);

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_ena   = 1'b0;
        w_mem_wena  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.cmd_valid_i) begin
                    unique case (w_cmd_op)
                        OpRead, OpRmw: w_state_nxt = StRd;
                        OpWrite:       w_state_nxt = StWr;
                        OpRsvd:        w_state_nxt = StResp;
                        default:       w_state_nxt = StResp;
                    endcase
                end
            end
            StRd: begin
                w_mem_ena   = 1'b1;
                w_state_nxt = StRcap;
            end
            StRcap: begin
                // A failed read of an RMW never reaches the write phase.
                if ((r_op == OpRmw) && !bus.mem_err_i) begin
                    w_state_nxt = StWr;
                end else begin
                    w_state_nxt = StResp;
                end
            end
            StWr: begin
                w_mem_ena   = 1'b1;
                w_mem_wena  = 1'b1;
                w_state_nxt = StWcap;
            end
            StWcap: begin
                w_state_nxt = StResp;
            end
            StResp: begin
                if (bus.rsp_ready_i) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            r_op        <= OpRead;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_op        <= w_cmd_op;
                r_addr      <= bus.cmd_addr_i;
                r_wdata     <= bus.cmd_wdata_i;
                r_mask      <= bus.cmd_mask_i;
                r_rsp_rdata <= '0;
                r_rsp_err   <= (w_cmd_op == OpRsvd);
            end
            if (r_state == StRcap) begin
                r_rsp_rdata <= bus.mem_rdata_i;
                r_rsp_err   <= bus.mem_err_i;
                if (r_op == OpRmw) begin
                    r_wdata <= (bus.mem_rdata_i & ~r_mask) | (r_wdata & r_mask);
                end
            end
            if (r_state == StWcap) begin
                r_rsp_err <= r_rsp_err | bus.mem_err_i;
            end
            if (w_rsp_hs && r_rsp_err && (r_err_cnt != ErrCntMax)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign bus.cmd_ready_o = (r_state == StIdle);
    assign bus.mem_ena_o   = w_mem_ena;
    assign bus.mem_wena_o  = w_mem_wena;
    assign bus.mem_addr_o  = w_mem_ena ? r_addr : '0;
    assign bus.mem_wdata_o = w_mem_wena ? r_wdata : '0;
    assign bus.rsp_valid_o = (r_state == StResp);
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.busy_o      = (r_state != StIdle);
    assign bus.err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_portgroup_mem_initiator.sv
// Scoreboard bench: stimulus queues expected strobes/responses, negedge monitors check them.
module tb_portgroup_mem_initiator;
    import portgroup_mem_initiator_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } rsp_t;

    typedef struct {
        logic        wena;
        logic [12:0] addr;
        logic [31:0] wdata;
    } stb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    portgroup_mem_initiator_if #(.addr_width_p(13), .data_width_p(32)) bus ();

    portgroup_mem_initiator #(.addr_width_p(13), .data_width_p(32)) dut (
        .main_clk_i (clk),
        .main_rst_i (rst),
        .bus        (bus)
    );

    rsp_t        rsp_q[$];
    stb_t        stb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [31:0] rd_value = 32'h0;
    logic        rd_err = 1'b0;
    logic        wr_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responds one cycle after each strobe.
    always @(posedge clk) begin
        bus.mem_rdata_i <= (bus.mem_ena_o && !bus.mem_wena_o) ? rd_value : 32'h0;
        bus.mem_err_i   <= bus.mem_ena_o && (bus.mem_wena_o ? wr_err : rd_err);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors.
    logic        prev_valid = 1'b0;
    int          first_cyc = 0;
    int          hs_cyc = -100;
    logic [31:0] hold_rdata;
    logic        hold_err;
    stb_t        s_mon;
    rsp_t        r_mon;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_ena_o) begin
                if (stb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: wena=%0b addr=%0h wdata=%0h",
                             bus.mem_wena_o, bus.mem_addr_o, bus.mem_wdata_o);
                end else begin
                    s_mon = stb_q.pop_front();
                    check("strobe_wena", 64'(bus.mem_wena_o), 64'(s_mon.wena));
                    check("strobe_addr", 64'(bus.mem_addr_o), 64'(s_mon.addr));
                    check("strobe_wdata", 64'(bus.mem_wdata_o), 64'(s_mon.wdata));
                end
            end else begin
                check("idle_wena", 64'(bus.mem_wena_o), 64'd0);
                check("idle_addr", 64'(bus.mem_addr_o), 64'd0);
                check("idle_wdata", 64'(bus.mem_wdata_o), 64'd0);
            end
            if (bus.rsp_valid_o) begin
                check("cmd_ready_during_resp", 64'(bus.cmd_ready_o), 64'd0);
                if (!prev_valid) begin
                    first_cyc  = cyc;
                    hold_rdata = bus.rsp_rdata_o;
                    hold_err   = bus.rsp_err_o;
                end else begin
                    check("rsp_rdata_stable", 64'(bus.rsp_rdata_o), 64'(hold_rdata));
                    check("rsp_err_stable", 64'(bus.rsp_err_o), 64'(hold_err));
                end
                if (bus.rsp_ready_i) begin
                    hs_cyc = cyc;
                    if (rsp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: rdata=%0h err=%0b",
                                 bus.rsp_rdata_o, bus.rsp_err_o);
                    end else begin
                        r_mon = rsp_q.pop_front();
                        check("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(r_mon.rdata));
                        check("rsp_err", 64'(bus.rsp_err_o), 64'(r_mon.err));
                        check("rsp_latency", 64'(first_cyc - r_mon.acc), 64'(r_mon.lat));
                    end
                end
            end
            prev_valid = bus.rsp_valid_o;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic push_stb(input logic wena, input logic [12:0] addr, input logic [31:0] wdata);
        stb_t s;
        s.wena  = wena;
        s.addr  = addr;
        s.wdata = wdata;
        stb_q.push_back(s);
    endtask

    task automatic issue(input logic [1:0] op, input logic [12:0] addr, input logic [31:0] wdata,
                         input logic [31:0] mask, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat, input bit want_rsp,
                         output int acc);
        bit   got = 1'b0;
        rsp_t r;
        acc = -1;
        @(negedge clk);
        bus.cmd_op_i    = op;
        bus.cmd_addr_i  = addr;
        bus.cmd_wdata_i = wdata;
        bus.cmd_mask_i  = mask;
        bus.cmd_valid_i = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            if (bus.cmd_ready_o) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: cmd_ready_o stayed 0, required 1");
        end else begin
            acc = cyc;
            if (want_rsp) begin
                r.rdata = exp_rdata;
                r.err   = exp_err;
                r.acc   = acc;
                r.lat   = exp_lat;
                rsp_q.push_back(r);
            end
        end
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && stb_q.size() == 0 && !bus.busy_o) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: rsp_q=%0d stb_q=%0d busy=%0b, required empty/idle",
                     rsp_q.size(), stb_q.size(), bus.busy_o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    int acc;
    int acc2;

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 2'd0;
        bus.cmd_addr_i  = 13'h0;
        bus.cmd_wdata_i = 32'h0;
        bus.cmd_mask_i  = 32'h0;
        bus.rsp_ready_i = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_mem_ena", 64'(bus.mem_ena_o), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err_o), 64'd0);
        check("rst_err_cnt", 64'(bus.err_cnt_o), 64'd0);

        // READ
        rd_value = 32'hDEADBEEF;
        push_stb(1'b0, 13'h0004, 32'h0);
        issue(2'd0, 13'h0004, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, acc);
        wait_idle();

        // RMW merge
        rd_value = 32'hFFFF0000;
        push_stb(1'b0, 13'h0010, 32'h0);
        push_stb(1'b1, 13'h0010, 32'hFFFF5678);
        issue(2'd2, 13'h0010, 32'h12345678, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 5, 1'b1, acc);
        wait_idle();

        // RMW with read error: no write phase
        check("err_cnt_before_rmw_err", 64'(bus.err_cnt_o), 64'd0);
        rd_value = 32'hAAAA5555;
        rd_err   = 1'b1;
        push_stb(1'b0, 13'h0020, 32'h0);
        issue(2'd2, 13'h0020, 32'h11111111, 32'hFFFFFFFF, 32'hAAAA5555, 1'b1, 3, 1'b1, acc);
        wait_idle();
        rd_err = 1'b0;
        check("err_cnt_after_rmw_err", 64'(bus.err_cnt_o), 64'd1);

        // Reserved op
        issue(2'd3, 13'h0055, 32'h12345678, 32'h0, 32'h0, 1'b1, 1, 1'b1, acc);
        wait_idle();
        check("err_cnt_after_rsvd", 64'(bus.err_cnt_o), 64'd2);

        // WRITE, clean and with error at top address
        push_stb(1'b1, 13'h0123, 32'hCAFEF00D);
        issue(2'd1, 13'h0123, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0, 3, 1'b1, acc);
        wait_idle();
        wr_err = 1'b1;
        push_stb(1'b1, 13'h1FFF, 32'h0F0F0F0F);
        issue(2'd1, 13'h1FFF, 32'h0F0F0F0F, 32'h0, 32'h0, 1'b1, 3, 1'b1, acc);
        wait_idle();
        wr_err = 1'b0;
        check("err_cnt_after_wr_err", 64'(bus.err_cnt_o), 64'd3);

        // READ with error
        rd_value = 32'h13579BDF;
        rd_err   = 1'b1;
        push_stb(1'b0, 13'h0000, 32'h0);
        issue(2'd0, 13'h0000, 32'h0, 32'h0, 32'h13579BDF, 1'b1, 3, 1'b1, acc);
        wait_idle();
        rd_err = 1'b0;
        check("err_cnt_after_rd_err", 64'(bus.err_cnt_o), 64'd4);

        // Response back-pressure for 10 cycles, next command queued behind it
        rd_value = 32'h0BADF00D;
        @(posedge clk);
        #1 bus.rsp_ready_i = 1'b0;
        push_stb(1'b0, 13'h0040, 32'h0);
        issue(2'd0, 13'h0040, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, 3, 1'b1, acc);
        fork
            begin
                for (int i = 0; i < 20 && !bus.rsp_valid_o; i++) @(negedge clk);
                repeat (10) @(posedge clk);
                #1 bus.rsp_ready_i = 1'b1;
            end
            begin
                push_stb(1'b1, 13'h0041, 32'h55AA55AA);
                issue(2'd1, 13'h0041, 32'h55AA55AA, 32'h0, 32'h0, 1'b0, 3, 1'b1, acc2);
            end
        join
        check("accept_after_handshake", 64'(acc2 - hs_cyc), 64'd1);
        wait_idle();

        // Saturation over 256 errors
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("err_cnt_cleared", 64'(bus.err_cnt_o), 64'd0);
        for (int i = 0; i < 256; i++) begin
            issue(2'd3, 13'(i), 32'h0, 32'h0, 32'h0, 1'b1, 1, 1'b1, acc);
            wait_idle();
            if (i == 253) check("err_cnt_254", 64'(bus.err_cnt_o), 64'hFE);
            if (i == 254) check("err_cnt_255", 64'(bus.err_cnt_o), 64'hFF);
        end
        check("err_cnt_saturated", 64'(bus.err_cnt_o), 64'hFF);

        // Reset during WR: strobe happens, then nothing more
        push_stb(1'b1, 13'h0077, 32'h11112222);
        issue(2'd1, 13'h0077, 32'h11112222, 32'h0, 32'h0, 1'b0, 3, 1'b0, acc);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
            check("abort_not_busy", 64'(bus.busy_o), 64'd0);
        end
        check("abort_err_cnt", 64'(bus.err_cnt_o), 64'd0);
        check("abort_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
        check("abort_strobe_seen", 64'(stb_q.size()), 64'd0);

        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/portgroup_mem_initiator.md
PORTGROUP_MEM_INITIATOR -- requirements
Module: portgroup_mem_initiator

Interface
REQ-001 SHALL have parameter addr_width_p, default 13, meaning mem word-address width.
REQ-002 SHALL have parameter data_width_p, default 32, meaning mem data width.
REQ-003 SHALL have one clock and a synchronous active-high reset: main_clk_i, single clock; main_rst_i, synchronous active-high reset.
REQ-004 SHALL have ports, one per line: name, direction, width, meaning.
- main_clk_i  in  1  clock
- main_rst_i  in  1  synchronous reset, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  2  0=READ, 1=WRITE, 2=RMW, 3=reserved
- cmd_addr_i  in  addr_width_p  target word address
- cmd_wdata_i  in  data_width_p  write data
- cmd_mask_i  in  data_width_p  RMW bit mask (1=take wdata bit)
- mem_ena_o  out  1  mem access strobe
- mem_addr_o  out  addr_width_p  mem address
- mem_wena_o  out  1  1=write, 0=read
- mem_wdata_o  out  data_width_p  mem write data
- mem_rdata_i  in  data_width_p  read data, valid the cycle after mem_ena_o
- mem_err_i  in  1  access error, valid the cycle after mem_ena_o
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  data_width_p  read data (READ/RMW old value)
- rsp_err_o  out  1  error flag
- busy_o  out  1  FSM not IDLE
- err_cnt_o  out  8  saturating error counter

Function
REQ-005 SHALL implement FSM states IDLE, RD, RCAP, WR, WCAP, RESP.
REQ-006 cmd_ready_o SHALL be 1 only in IDLE; a command is captured into internal registers on cmd_valid_i&cmd_ready_o.
REQ-007 IDLE transitions on accept: READ/RMW -> RD; WRITE -> WR; op 3 -> RESP with rsp_err_o=1, rsp_rdata_o=0, no mem access.
REQ-008 RD SHALL drive mem_ena_o=1, mem_wena_o=0, mem_addr_o=captured addr for exactly one cycle, then go to RCAP.
REQ-009 RCAP SHALL register mem_rdata_i into rsp_rdata_o and mem_err_i into rsp_err_o; READ -> RESP; RMW with err -> RESP (no write); RMW without err -> WR with wdata = (rdata & ~mask) | (wdata & mask).
REQ-010 WR SHALL drive mem_ena_o=1, mem_wena_o=1, mem_addr_o, mem_wdata_o for exactly one cycle, then go to WCAP.
REQ-011 WCAP SHALL OR mem_err_i into rsp_err_o (WRITE: rsp_rdata_o=0) and go to RESP.
REQ-012 RESP SHALL hold rsp_valid_o=1 and stable rsp_* until rsp_ready_i=1, then go to IDLE; the next command is accepted no earlier than the following cycle.
REQ-013 Latency SHALL be READ/WRITE: rsp_valid_o 3 cycles after accept; RMW: 5 cycles; op 3: 1 cycle.
REQ-014 mem_ena_o, mem_wena_o SHALL be 0 outside RD/WR; mem_addr_o/mem_wdata_o SHALL be 0 when mem_ena_o=0.
REQ-015 err_cnt_o SHALL increment by 1 on each RESP handshake with rsp_err_o=1 and saturate at 8'hFF.
REQ-016 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-017 On main_rst_i=1 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 except cmd_ready_o=1 in the following cycle; err_cnt_o SHALL clear to 0.
REQ-018 Reset mid-transaction SHALL abort it with no response and no further mem strobe.

Structure
REQ-019 Package portgroup_mem_initiator_pkg SHALL hold the op enum (READ, WRITE, RMW, RSVD) and the FSM state enum.
REQ-020 The block SHALL be a single module with no sub-module; the RMW merge is inline logic.

Verification
REQ-021 The bench SHALL cover READ at addr 13'h0004 with mem_rdata_i=32'hDEADBEEF -> one strobe with wena=0, rsp_rdata_o=32'hDEADBEEF, rsp_err_o=0, rsp_valid_o 3 cycles after accept.
REQ-022 The bench SHALL cover RMW at 13'h0010 with old 32'hFFFF0000, wdata 32'h12345678 and mask 32'h0000FFFF -> a write of 32'hFFFF5678, rsp_rdata_o=32'hFFFF0000, rsp_valid_o 5 cycles after accept.
REQ-023 The bench SHALL cover RMW with mem_err_i=1 in RCAP -> no write strobe, rsp_err_o=1, err_cnt_o goes 0->1.
REQ-024 The bench SHALL cover op 3 -> no mem_ena_o, rsp_err_o=1 the cycle after accept.
REQ-025 The bench SHALL cover rsp_ready_i held low for 10 cycles -> rsp_* stable, cmd_ready_o=0 throughout, and a new command accepted the cycle after the handshake.
REQ-026 The bench SHALL cover 256 consecutive errors -> err_cnt_o=8'hFF, with main_rst_i asserted in WR -> no WCAP or response, and err_cnt_o=0 after reset.
